// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the gate-sequence producer.
package sequence_generator_pkg;

    localparam int SEQ_INDEX_BITS    = 4;
    localparam int HIGHEST_SEQ_INDEX = 11;
    localparam int HIGHEST_GATE      = 4;
    localparam int GATE_BITS         = 5;
    localparam int SEQ_LEN_BITS      = SEQ_INDEX_BITS + 1;
    localparam int COUNT_BITS        = 32;

    typedef logic [SEQ_INDEX_BITS-1:0] seq_index_t;
    typedef logic [GATE_BITS-1:0]      gate_t;
    typedef logic [SEQ_LEN_BITS-1:0]   seq_len_t;
    typedef logic [COUNT_BITS-1:0]     count_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic count_t sat_incr(input count_t v);
        return (&v) ? v : v + count_t'(1);
    endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Gate-item handshake between the sequence generator (master) and the
// sequence multiplier (slave). ready is a one-cycle item strobe; available
// is the multiplier's back-pressure.
interface sequence_generator_if;
    import sequence_generator_pkg::*;

    seq_index_t seq_index;
    gate_t      seq_gate;
    logic       first;
    logic       ready;
    logic       available;

    modport master (
        output seq_index,
        output seq_gate,
        output first,
        output ready,
        input  available
    );

    modport slave (
        input  seq_index,
        input  seq_gate,
        input  first,
        input  ready,
        output available
    );

endinterface

// File: rtl/sequence_generator_odometer_incr.sv
// Combinational odometer step over the active digits g[0..seq_len-1].
// k_o is the lowest digit that can still count up; that digit increments and
// every digit below it wraps to zero. carry_o means every active digit was
// already at MAX_GATE, so the caller must grow the length or finish.
module sequence_generator_odometer_incr
    import sequence_generator_pkg::*;
#(
    parameter int MAX_INDEX = HIGHEST_SEQ_INDEX,
    parameter int MAX_GATE  = HIGHEST_GATE
) (
    input  logic [MAX_INDEX:0][GATE_BITS-1:0] g_i,
    input  seq_len_t                          seq_len_i,
    output seq_index_t                        k_o,
    output logic [MAX_INDEX:0][GATE_BITS-1:0] g_next_o,
    output logic                              carry_o
);

    logic found_c;

    // Find the lowest active digit that is not yet saturated.
    always_comb begin
        found_c = 1'b0;
        k_o     = '0;
        for (int i = 0; i <= MAX_INDEX; i++) begin
            if (!found_c && (i < int'(seq_len_i)) && (g_i[i] < gate_t'(MAX_GATE))) begin
                found_c = 1'b1;
                k_o     = seq_index_t'(i);
            end
        end
    end

    assign carry_o = !found_c;

    // Build the incremented digit vector; digits above k are untouched.
    always_comb begin
        g_next_o = g_i;
        for (int i = 0; i <= MAX_INDEX; i++) begin
            if (found_c) begin
                if (seq_index_t'(i) < k_o) begin
                    g_next_o[i] = '0;
                end else if (seq_index_t'(i) == k_o) begin
                    g_next_o[i] = g_i[i] + gate_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Producer side of the gate-sequence handshake. Enumerates every gate
// sequence of length 1..MAX_INDEX+1 odometer style and streams each one
// highest index first. After the first sequence of a given length only the
// indices at or below the changed digit are re-streamed, so the multiplier
// can keep its cached prefix.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | parked; start (and not finished) begins or resumes enumeration
//   ISSUE | one cycle: ready high, item at index cur presented
//   WAIT  | item held stable until available; cur==0 ack closes a sequence
//   NEXT  | one cycle: odometer step, length growth, or exhaustion
//   DONE  | all sequences streamed; only reset leaves
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int MAX_INDEX = HIGHEST_SEQ_INDEX,
    parameter int MAX_GATE  = HIGHEST_GATE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    sequence_generator_if.master seq_if,
    output seq_len_t             seq_len,
    output count_t               seq_count,
    output logic                 busy,
    output logic                 finished
);

    localparam seq_len_t LEN_MAX = seq_len_t'(MAX_INDEX + 1);

    typedef logic [MAX_INDEX:0][GATE_BITS-1:0] gate_vec_t;

    state_e     state_q,     state_d;
    gate_vec_t  g_q,         g_d;
    seq_len_t   seq_len_q,   seq_len_d;
    seq_index_t cur_q,       cur_d;
    count_t     seq_count_q, seq_count_d;
    logic       finished_q,  finished_d;

    seq_index_t odo_k;
    gate_vec_t  odo_g_next;
    logic       odo_carry;

    logic       ready_c;
    logic       first_c;
    gate_t      gate_c;
    logic       busy_c;

    sequence_generator_odometer_incr #(
        .MAX_INDEX (MAX_INDEX),
        .MAX_GATE  (MAX_GATE)
    ) u_odometer (
        .g_i       (g_q),
        .seq_len_i (seq_len_q),
        .k_o       (odo_k),
        .g_next_o  (odo_g_next),
        .carry_o   (odo_carry)
    );

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            seq_len_q   <= '0;
            cur_q       <= '0;
            seq_count_q <= '0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            seq_len_q   <= seq_len_d;
            cur_q       <= cur_d;
            seq_count_q <= seq_count_d;
            finished_q  <= finished_d;
        end
    end

    // Next-state and datapath update for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        seq_len_d   = seq_len_q;
        cur_d       = cur_q;
        seq_count_d = seq_count_q;
        finished_d  = finished_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !finished_q) begin
                    if (seq_len_q == '0) begin
                        seq_len_d = seq_len_t'(1);
                        cur_d     = '0;
                        state_d   = ST_ISSUE;
                    end else begin
                        // Odometer state was kept across the pause; step past
                        // the sequence that completed before stop.
                        state_d = ST_NEXT;
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (seq_if.available) begin
                    if (cur_q != '0) begin
                        cur_d   = cur_q - seq_index_t'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        // stop only takes effect here, so a partially
                        // streamed sequence is never abandoned.
                        seq_count_d = sat_incr(seq_count_q);
                        state_d     = stop ? ST_IDLE : ST_NEXT;
                    end
                end
            end

            ST_NEXT: begin
                if (!odo_carry) begin
                    g_d     = odo_g_next;
                    cur_d   = odo_k;
                    state_d = ST_ISSUE;
                end else if (seq_len_q == LEN_MAX) begin
                    finished_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // New length: all digits restart at zero and the whole
                    // sequence streams from the new top index (old seq_len).
                    seq_len_d = seq_len_q + seq_len_t'(1);
                    g_d       = '0;
                    cur_d     = seq_index_t'(seq_len_q);
                    state_d   = ST_ISSUE;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: item fields come straight from cur/g, so they stay
    // stable through WAIT without extra holding registers.
    always_comb begin
        ready_c = (state_q == ST_ISSUE);
        busy_c  = (state_q != ST_IDLE) && (state_q != ST_DONE);
        first_c = (seq_len_q != '0) && (seq_len_t'(cur_q) == (seq_len_q - seq_len_t'(1)));
        gate_c  = '0;
        for (int i = 0; i <= MAX_INDEX; i++) begin
            if (cur_q == seq_index_t'(i)) begin
                gate_c = g_q[i];
            end
        end
    end

    assign seq_if.ready     = ready_c;
    assign seq_if.seq_index = cur_q;
    assign seq_if.seq_gate  = gate_c;
    assign seq_if.first     = first_c;

    assign seq_len   = seq_len_q;
    assign seq_count = seq_count_q;
    assign busy      = busy_c;
    assign finished  = finished_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator. Expected items are queued by the
// stimulus; a negedge monitor pops and compares whenever ready is seen.
module tb_sequence_generator;
    import sequence_generator_pkg::*;

    typedef struct {
        logic [3:0] idx;
        logic [4:0] gate;
        logic       first;
        logic       cont;    // continues the stream of the previous item
    } item_t;

    localparam int AV_MANUAL = 0;
    localparam int AV_ECHO   = 1;
    localparam int AV_ONE    = 2;

    logic     clk    = 1'b0;
    logic     reset  = 1'b1;
    logic     start  = 1'b0;
    logic     stop   = 1'b0;
    logic     reset2 = 1'b1;
    logic     start2 = 1'b0;
    seq_len_t seq_len, seq_len2;
    count_t   seq_count, seq_count2;
    logic     busy, finished, busy2, finished2;

    int       checks   = 0;
    int       failures = 0;
    item_t    exp_q[$];
    int       av_mode    = AV_ECHO;
    logic     man_av     = 1'b0;
    logic     spacing_on = 1'b0;
    int       items2  = 0;
    int       firsts2 = 0;

    sequence_generator_if sif();
    sequence_generator_if sif2();

    always #5 clk = ~clk;

    sequence_generator #(.MAX_INDEX(1), .MAX_GATE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .seq_if    (sif),
        .seq_len   (seq_len),
        .seq_count (seq_count),
        .busy      (busy),
        .finished  (finished)
    );

    sequence_generator #(.MAX_INDEX(2), .MAX_GATE(2)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .start     (start2),
        .stop      (1'b0),
        .seq_if    (sif2),
        .seq_len   (seq_len2),
        .seq_count (seq_count2),
        .busy      (busy2),
        .finished  (finished2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int idx, input int gate, input int first, input int cont);
        item_t it;
        it.idx   = idx[3:0];
        it.gate  = gate[4:0];
        it.first = first[0];
        it.cont  = cont[0];
        exp_q.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (!sif.ready && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, sif.ready, 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_finished(input string name, input int budget);
        int n = 0;
        while (!finished && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, finished, 1);
    endtask

    // Serve one item by hand: hold available low for 'hold' WAIT cycles
    // (checking the item stays put), then pulse it for one cycle.
    task automatic serve(input string name, input int hold, input int idx, input int gate, input int first);
        wait_ready(name, 20);
        tick(1);
        for (int h = 0; h < hold; h++) begin
            chk("bp_no_ready", sif.ready, 0);
            chk("bp_idx_stable", sif.seq_index, idx);
            chk("bp_gate_stable", sif.seq_gate, gate);
            chk("bp_first_stable", sif.first, first);
            tick(1);
        end
        man_av = 1'b1;
        tick(1);
        man_av = 1'b0;
    endtask

    // Multiplier model for available.
    initial begin : responder
        logic prev;
        prev = 1'b0;
        sif.available  = 1'b0;
        sif2.available = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (av_mode)
                AV_ECHO: sif.available = prev;
                AV_ONE:  sif.available = 1'b1;
                default: sif.available = man_av;
            endcase
            prev = sif.ready;
        end
    end

    // Scoreboard monitor for the small-config DUT.
    initial begin : monitor
        int    cyc;
        int    last_issue;
        logic  prev_ready;
        item_t e;
        cyc        = 0;
        last_issue = -1;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                last_issue = -1;
                prev_ready = 1'b0;
            end else begin
                if (sif.ready) begin
                    chk("ready_one_cycle", prev_ready, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_item: actual idx=%0d gate=%0d first=%0d required=no item",
                                 sif.seq_index, sif.seq_gate, sif.first);
                    end else begin
                        e = exp_q.pop_front();
                        chk("item_idx", sif.seq_index, e.idx);
                        chk("item_gate", sif.seq_gate, e.gate);
                        chk("item_first", sif.first, e.first);
                        if (spacing_on && last_issue >= 0)
                            chk("item_spacing", cyc - last_issue, e.cont ? 2 : 3);
                    end
                    last_issue = cyc;
                end
                prev_ready = sif.ready;
            end
        end
    end

    // Item counter for the 3-gate / length-3 DUT.
    initial begin : monitor2
        forever begin
            @(negedge clk);
            if (!reset2 && sif2.ready) begin
                items2++;
                if (sif2.first) firsts2++;
                chk("dut2_idx_in_range", (sif2.seq_index <= 4'd2), 1);
                chk("dut2_gate_in_range", (sif2.seq_gate <= 5'd2), 1);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;

        // Reset state
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_ready", sif.ready, 0);
        chk("rst_seq_index", sif.seq_index, 0);
        chk("rst_seq_gate", sif.seq_gate, 0);
        chk("rst_first", sif.first, 0);
        chk("rst_seq_len", seq_len, 0);
        chk("rst_seq_count", seq_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);

        // Full enumeration with available echoed one cycle after ready
        av_mode    = AV_ECHO;
        spacing_on = 1'b1;
        push(0, 0, 1, 0);
        push(0, 1, 1, 0);
        push(1, 0, 1, 0); push(0, 0, 0, 1);
        push(0, 1, 0, 0);
        push(1, 1, 1, 0); push(0, 0, 0, 1);
        push(0, 1, 0, 0);
        start = 1'b1;
        wait_drain("full_items_drained", 100);
        wait_finished("full_finished", 20);
        chk("full_seq_count", seq_count, 6);
        chk("full_seq_len", seq_len, 2);
        chk("full_busy", busy, 0);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(2);
        chk("done_busy", busy, 0);
        chk("done_finished", finished, 1);
        chk("done_seq_count", seq_count, 6);

        // stop while sequence [g1=1,g0=0] is mid-stream
        do_reset();
        spacing_on = 1'b0;
        push(0, 0, 1, 0);
        push(0, 1, 1, 0);
        push(1, 0, 1, 0); push(0, 0, 0, 1);
        push(0, 1, 0, 0);
        push(1, 1, 1, 0); push(0, 0, 0, 1);
        start = 1'b1;
        n = 0;
        while (seq_count != 4 && n < 60) begin
            tick(1);
            n++;
        end
        chk("stop_reach_count4", seq_count, 4);
        wait_ready("stop_top_item_ready", 10);
        stop  = 1'b1;
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick(1);
            n++;
        end
        chk("stop_busy", busy, 0);
        chk("stop_seq_count", seq_count, 5);
        chk("stop_finished", finished, 0);
        chk("stop_seq_len", seq_len, 2);
        wait_drain("stop_items_drained", 5);
        tick(6);
        chk("stop_idle_seq_count", seq_count, 5);
        stop = 1'b0;
        push(0, 1, 0, 0);
        start = 1'b1;
        wait_drain("resume_item", 20);
        wait_finished("resume_finished", 20);
        chk("resume_seq_count", seq_count, 6);
        start = 1'b0;

        // Reset while in WAIT
        do_reset();
        push(0, 0, 1, 0);
        start = 1'b1;
        wait_ready("rw_first_ready", 10);
        tick(1);
        chk("rw_in_wait_busy", busy, 1);
        reset = 1'b1;
        tick(1);
        chk("rw_ready", sif.ready, 0);
        chk("rw_seq_len", seq_len, 0);
        chk("rw_seq_count", seq_count, 0);
        chk("rw_busy", busy, 0);
        reset = 1'b0;
        push(0, 0, 1, 0);
        wait_drain("rw_reemit", 10);
        chk("rw_seq_len_after", seq_len, 1);
        start = 1'b0;

        // Back-pressure, then available held constantly high
        do_reset();
        av_mode = AV_MANUAL;
        man_av  = 1'b0;
        push(0, 0, 1, 0);
        push(0, 1, 1, 0);
        push(1, 0, 1, 0); push(0, 0, 0, 1);
        start = 1'b1;
        serve("bp_s1", 0, 0, 0, 1);
        serve("bp_s2", 0, 0, 1, 1);
        serve("bp_s3_top", 10, 1, 0, 1);
        chk("bp_next_issue_1cyc", sif.ready, 1);
        serve("bp_s3_low", 0, 0, 0, 0);
        av_mode    = AV_ONE;
        spacing_on = 1'b1;
        push(0, 1, 0, 0);
        push(1, 1, 1, 0); push(0, 0, 0, 1);
        push(0, 1, 0, 0);
        wait_drain("const_items_drained", 60);
        wait_finished("const_finished", 20);
        chk("const_seq_count", seq_count, 6);
        start = 1'b0;

        // Three gates, lengths 1..3: 3+9+27 sequences, 54 streamed items
        reset2 = 1'b0;
        start2 = 1'b1;
        n = 0;
        while (!finished2 && n < 2000) begin
            tick(1);
            n++;
        end
        chk("dut2_finished", finished2, 1);
        chk("dut2_seq_count", seq_count2, 39);
        chk("dut2_items", items2, 54);
        chk("dut2_first_items", firsts2, 9);
        chk("dut2_seq_len", seq_len2, 3);
        chk("dut2_busy", busy2, 0);
        start2 = 1'b0;
        tick(2);
        start2 = 1'b1;
        tick(3);
        chk("dut2_done_hold_count", seq_count2, 39);
        chk("dut2_done_hold_items", items2, 54);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
